// File: rtl/flu_issue_scheduler.sv
// flu_issue_scheduler: issue gate for the fixed-latency unit cluster.
// Decides when issue may enter the ALU/branch/CSR/mul-div path without
// two results colliding on the shared write-back port.
//
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   flush_i            drop all tracked state, suppress strobes
//   issue_valid_i      issue offers an FLU instruction
//   issue_fu_i         unit code (0 NONE,1 ALU,2 BR,3 CSR,4 MUL,5 DIV)
//   issue_trans_id_i   scoreboard ID of the offered instruction
//   issue_ready_o      offered instruction is accepted this cycle
//   *_valid_o          per-unit strobes (DIV drives mult_valid_o)
//   csr_commit_i       commit retires the buffered CSR op
//   div_valid_i        divider result on the port this cycle
//   wb_pending_o/_id_o multiply result due this cycle and its ID
//   div_busy_o         division in flight
//   csr_pending_o      CSR buffer occupied
module flu_issue_scheduler #(
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned MULT_LATENCY  = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    input  logic [2:0]               issue_fu_i,
    input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
    output logic                     issue_ready_o,
    output logic                     alu_valid_o,
    output logic                     branch_valid_o,
    output logic                     csr_valid_o,
    output logic                     mult_valid_o,
    input  logic                     csr_commit_i,
    input  logic                     div_valid_i,
    output logic                     wb_pending_o,
    output logic [TRANS_ID_BITS-1:0] wb_pending_id_o,
    output logic                     div_busy_o,
    output logic                     csr_pending_o
);

    localparam logic [2:0] FU_ALU    = 3'd1;
    localparam logic [2:0] FU_BRANCH = 3'd2;
    localparam logic [2:0] FU_CSR    = 3'd3;
    localparam logic [2:0] FU_MUL    = 3'd4;
    localparam logic [2:0] FU_DIV    = 3'd5;

    logic [MULT_LATENCY-1:0]                    wb_q, wb_d;
    logic [MULT_LATENCY-1:0][TRANS_ID_BITS-1:0] id_q, id_d;
    logic div_busy_q, div_busy_d;
    logic csr_pending_q, csr_pending_d;

    logic busy;
    logic accept;
    logic acc_mul;
    logic acc_div;
    logic acc_csr;

    always_comb begin
        busy          = div_busy_q | csr_pending_q;
        issue_ready_o = 1'b1;
        case (issue_fu_i)
            FU_ALU, FU_BRANCH, FU_CSR:
                issue_ready_o = ~busy & ~wb_q[0];
            FU_MUL:
                issue_ready_o = ~busy;
            // the multiplier is idle only once every slot has drained
            FU_DIV:
                issue_ready_o = ~busy & ~(|wb_q);
            default:
                issue_ready_o = 1'b1;
        endcase
    end

    assign accept = issue_valid_i & issue_ready_o & ~flush_i;

    assign alu_valid_o    = accept & (issue_fu_i == FU_ALU);
    assign branch_valid_o = accept & (issue_fu_i == FU_BRANCH);
    assign acc_csr        = accept & (issue_fu_i == FU_CSR);
    assign acc_mul        = accept & (issue_fu_i == FU_MUL);
    assign acc_div        = accept & (issue_fu_i == FU_DIV);
    assign csr_valid_o    = acc_csr;
    assign mult_valid_o   = acc_mul | acc_div;

    always_comb begin
        wb_d = '0;
        id_d = '0;
        for (int unsigned k = 0; k + 1 < MULT_LATENCY; k++) begin
            wb_d[k] = wb_q[k+1];
            id_d[k] = id_q[k+1];
        end
        wb_d[MULT_LATENCY-1] = acc_mul;
        id_d[MULT_LATENCY-1] = acc_mul ? issue_trans_id_i : '0;

        div_busy_d = div_busy_q;
        if (acc_div) begin
            div_busy_d = 1'b1;
        end else if (div_valid_i) begin
            div_busy_d = 1'b0;
        end

        csr_pending_d = csr_pending_q;
        if (acc_csr) begin
            csr_pending_d = 1'b1;
        end else if (csr_commit_i) begin
            csr_pending_d = 1'b0;
        end

        if (flush_i) begin
            wb_d          = '0;
            id_d          = '0;
            div_busy_d    = 1'b0;
            csr_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_q          <= '0;
            id_q          <= '0;
            div_busy_q    <= 1'b0;
            csr_pending_q <= 1'b0;
        end else begin
            wb_q          <= wb_d;
            id_q          <= id_d;
            div_busy_q    <= div_busy_d;
            csr_pending_q <= csr_pending_d;
        end
    end

    assign wb_pending_o    = wb_q[0];
    assign wb_pending_id_o = id_q[0];
    assign div_busy_o      = div_busy_q;
    assign csr_pending_o   = csr_pending_q;

endmodule
